// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : multicycle_pkg                                             |
// | Description : Shared types and select encodings for the multi-cycle      |
// |               RV32I controller: FSM state enum, opcodes, and the         |
// |               datapath mux-select / ALU-op / immediate-type constants.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU source A
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALU source B
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate type
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : multicycle_controller_if                                   |
// | Description : Controller <-> datapath/memory signal bundle.              |
// |               master : the controller (reads op/zero/mem_ready, drives   |
// |                        every strobe, select, status and counter)         |
// |               slave  : the datapath/memory side                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             adr_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             reg_write;
  logic             mem_write;
  logic             illegal;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero, mem_ready,
    output ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, imm_src, reg_write, mem_write, illegal, state_o, retired
  );

  modport slave (
    output op, zero, mem_ready,
    input  ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, imm_src, reg_write, mem_write, illegal, state_o, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_imm_src_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imm_src_decoder                                            |
// | Description : Combinational opcode -> immediate-type decode.             |
// | Ports       : op      (in,  7) opcode                                    |
// |               imm_src (out, 2) 00 I, 01 S, 10 B, 11 J                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imm_src_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Main control FSM of the multi-cycle RV32I datapath.        |
// |               Sequences lw, sw, R-type, I-type ALU, beq and jal and      |
// |               counts retired instructions.                               |
// | Ports       : clk  (in) rising-edge clock                                |
// |               rst  (in) asynchronous active-high reset                   |
// |               bus  (multicycle_controller_if.master) op/zero/mem_ready   |
// |                    in; strobes, selects, illegal, state_o, retired out   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic [1:0]       w_imm_src;

  imm_src_decoder u_imm_src_decoder (
    .op      (bus.op),
    .imm_src (w_imm_src)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // An instruction retires on the last cycle of its sequence; MEMWRITE only
  // finishes once memory acknowledges the store.
  assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BEQ) ||
                    ((r_state == MEMWRITE) && bus.mem_ready);

  always_comb begin
    w_next         = r_state;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_WDATA;
    bus.result_src = RES_ALUOUT;
    bus.alu_op     = ALUOP_ADD;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALURESULT;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next = DECODE;
      end
      DECODE: begin
        // old_pc + imm is parked in alu_out as a possible branch target
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECR;
          OP_ITYPE:     w_next = EXECI;
          OP_BEQ:       w_next = BEQ;
          OP_JAL:       w_next = JAL;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_A;
        bus.alu_src_b = SRCB_IMM;
        w_next        = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        bus.result_src = RES_DATA;
        bus.reg_write  = 1'b1;
        w_next         = FETCH;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) w_next = FETCH;
      end
      EXECR: begin
        bus.alu_src_a = SRCA_A;
        bus.alu_op    = ALUOP_FUNCT;
        w_next        = ALUWB;
      end
      EXECI: begin
        bus.alu_src_a = SRCA_A;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_FUNCT;
        w_next        = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        w_next        = FETCH;
      end
      BEQ: begin
        bus.alu_src_a = SRCA_A;
        bus.alu_op    = ALUOP_SUB;
        bus.pc_write  = bus.zero;
        w_next        = FETCH;
      end
      JAL: begin
        // pc <- branch target (already in alu_out); old_pc+4 flows on to ALUWB
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
        w_next        = ALUWB;
      end
      TRAP: begin
        bus.illegal = 1'b1;
      end
      default: begin
        // unused encodings are treated as illegal
        w_next = TRAP;
      end
    endcase
  end

  assign bus.imm_src = w_imm_src;
  assign bus.state_o = r_state;
  assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback over several cycles for lw, sw, R-type, I-type ALU, beq and jal. It drives every datapath strobe and mux select: IR/PC write, address source, ALU source A/B, result source, register and memory write. It also drives the ALU-op class and immediate type. Memory is shared between instruction and data access, with a single-bit ready handshake.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
op  input  7  opcode, instr[6:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read/write this cycle
ir_write  output  1  load instr/old_pc registers
pc_write  output  1  load PC (pc_update | (branch & zero))
adr_src  output  1  0 = PC, 1 = alu_out
alu_src_a  output  2  00 pc, 01 old_pc, 10 a
alu_src_b  output  2  00 write_data, 01 imm_ext, 10 constant 4
result_src  output  2  00 alu_out, 01 data, 10 alu_result
alu_op  output  2  00 add, 01 sub, 10 decode from funct3/funct7
imm_src  output  2  00 I, 01 S, 10 B, 11 J
reg_write  output  1  register file write enable
mem_write  output  1  memory write enable
illegal  output  1  sticky; high while in TRAP
state_o  output  4  current state encoding (debug)
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset is asynchronous: state := FETCH, retired := 0. With mem_ready=0, all strobes are 0; selects take FETCH values.
- Outputs are Moore (state only), with these exceptions:
  - ir_write and pc_write in FETCH also depend on mem_ready.
  - pc_write in BEQ also depends on zero.
  - imm_src decodes combinationally from op: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Unlisted outputs are 0 / 00 in every state.
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (branch target into alu_out). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src 01, reg_write 1. Go to FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1. mem_write is held every cycle until mem_ready, then go to FETCH.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10. Go to ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10. Go to ALUWB.
- ALUWB: result_src 00, reg_write 1. Go to FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, pc_write = zero. Go to FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1. Go to ALUWB (writes old_pc+4 to rd).
- TRAP: all strobes 0, illegal 1. Absorbing; left only via rst.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE(ready), ALUWB or BEQ. It wraps at 2^CNT_W−1 -> 0.
- Cycle counts with mem_ready tied 1:
  - lw 5
  - sw 4
  - R/I 4
  - beq 3
  - jal 4
- Each cycle mem_ready is low in a wait state adds exactly one cycle.
- A reset mid-instruction aborts it. Strobes drop immediately (async) and no partial writeback occurs after reset deasserts.
- No X on any output for any op value.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP; 4-bit)
  - opcode localparams
  - alu_src_a/b, result_src, alu_op and imm_src select constants
- One combinational sub-module, imm_src_decoder (op -> imm_src), shared later with the single-cycle Decoder.

Test Plan:
- Reset while in MEMWRITE with mem_write=1 -> mem_write=0 asynchronously. After release: state FETCH, retired=0.
- mem_ready=1, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 with result_src=01 only in cycle 5; retired 0->1.
- op=0100011 with mem_ready low for 3 cycles in MEMWRITE -> mem_write held 4 cycles, then FETCH. Exactly one retired increment; reg_write never asserted.
- op=1100011: zero=1 -> pc_write=1 in BEQ cycle; zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- op=1101111 -> pc_write=1 in JAL, then ALUWB with reg_write=1, result_src=00. imm_src=11 throughout.
- op=1111111 -> TRAP after DECODE, illegal=1. No strobes for 100 cycles; retired frozen. Preload retired=2^32−1 and complete one R-type -> retired=0.
